// File: rtl/vga_timing_if.sv
// Pixel-pipeline side of the raster timing generator: tick in, syncs/strobes out.
// Coordinate outputs exist only when VGA_TIMING_COORD_EN is defined.
interface vga_timing_if;
  logic        i_tick;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_enable;
  logic        o_newline;
  logic        o_newframe;
`ifdef VGA_TIMING_COORD_EN
  logic [11:0] o_x;
  logic [11:0] o_y;

  modport master (input i_tick,
                  output o_hsync, o_vsync, o_enable, o_newline, o_newframe, o_x, o_y);
  modport slave  (output i_tick,
                  input o_hsync, o_vsync, o_enable, o_newline, o_newframe, o_x, o_y);
`else
  modport master (input i_tick,
                  output o_hsync, o_vsync, o_enable, o_newline, o_newframe);
  modport slave  (output i_tick,
                  input o_hsync, o_vsync, o_enable, o_newline, o_newframe);
`endif
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: h/v position counters advanced on the pixel tick, registered
// syncs and one-clk strobes. Optional o_x/o_y coordinate outputs under VGA_TIMING_COORD_EN.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // 13-bit limits so a window ending exactly at 4096 still compares correctly
  localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FRONT);
  localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [12:0] H_LST  = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FRONT);
  localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [12:0] V_LST  = 13'(V_TOTAL - 1);

  logic [11:0] h, v;
  logic [12:0] h_ext, v_ext;
  logic        h_last, v_last;
  logic        hsync_q, vsync_q, enable_q, newline_q, newframe_q;

  assign h_ext  = {1'b0, h};
  assign v_ext  = {1'b0, v};
  assign h_last = (h_ext == H_LST);
  assign v_last = (v_ext == V_LST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h          <= '0;
      v          <= '0;
      enable_q   <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
    end else if (vif.i_tick) begin
      enable_q   <= (h_ext < H_ACT) && (v_ext < V_ACT);
      newline_q  <= h_last;
      newframe_q <= h_last && v_last;
      hsync_q    <= ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync_q    <= ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
      if (h_last) begin
        h <= '0;
        v <= v_last ? 12'd0 : v + 12'd1;
      end else begin
        h <= h + 12'd1;
      end
    end else begin
      // between ticks only the strobes drop; syncs and position hold
      enable_q   <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
    end
  end

  assign vif.o_hsync    = hsync_q;
  assign vif.o_vsync    = vsync_q;
  assign vif.o_enable   = enable_q;
  assign vif.o_newline  = newline_q;
  assign vif.o_newframe = newframe_q;

`ifdef VGA_TIMING_COORD_EN
  logic [11:0] x_q, y_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (vif.i_tick) begin
      x_q <= h;
      y_q <= v;
    end
  end

  assign vif.o_x = x_q;
  assign vif.o_y = y_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: small-raster DUT checked every cycle against a tick-count model,
// plus a default-timing DUT pinned with literal expectations.
module tb_vga_timing;

  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 19
  localparam int FRAME = HT * VT;          // 608
  localparam bit SP = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if vif ();
  vga_timing_if vif2 ();

  vga_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(SP)
  ) dut (.clk(clk), .rst(rst), .vif(vif));

  vga_timing dut_dflt (.clk(clk), .rst(rst), .vif(vif2));

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Model: the k-th tick since reset emits raster position k mod FRAME.
  int unsigned n_ticks;
  int m_p, m_h, m_v;
  logic m_en, m_nl, m_nf, m_hs, m_vs;
  int m_x, m_y;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_ticks = 0;
      m_en = 0; m_nl = 0; m_nf = 0;
      m_hs = ~SP; m_vs = ~SP;
      m_x = 0; m_y = 0;
    end else if (vif.i_tick) begin
      m_p  = int'(n_ticks % FRAME);
      m_h  = m_p % HT;
      m_v  = m_p / HT;
      m_en = (m_h < HA) && (m_v < VA);
      m_nl = (m_h == HT - 1);
      m_nf = (m_p == FRAME - 1);
      m_hs = (m_h >= HA + HF && m_h < HA + HF + HS) ? SP : ~SP;
      m_vs = (m_v >= VA + VF && m_v < VA + VF + VS) ? SP : ~SP;
      m_x  = m_h;
      m_y  = m_v;
      n_ticks++;
    end else begin
      m_en = 0; m_nl = 0; m_nf = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("enable",   vif.o_enable,   m_en);
      check("newline",  vif.o_newline,  m_nl);
      check("newframe", vif.o_newframe, m_nf);
      check("hsync",    vif.o_hsync,    m_hs);
      check("vsync",    vif.o_vsync,    m_vs);
`ifdef VGA_TIMING_COORD_EN
      check("x", vif.o_x, m_x);
      check("y", vif.o_y, m_y);
`endif
    end
  end

  int cnt_en, cnt_nl, cnt_nf, first_nl, first_nf, first_nl2, first_hs2;
  bit found;

  initial begin
    vif.i_tick = 0;
    vif2.i_tick = 0;
    #1 rst = 0;
    chk_en = 1;
    repeat (3) @(negedge clk);
    check("rst_enable", vif.o_enable, 0);
    check("rst_hsync", vif.o_hsync, 1);
    check("rst_vsync", vif.o_vsync, 1);
    check("dflt_rst_hsync", vif2.o_hsync, 1);
    rst = 1;
    @(negedge clk);

    // continuous ticks: two small frames, and 1300 default-timing ticks
    vif.i_tick = 1;
    vif2.i_tick = 1;
    cnt_en = 0; cnt_nl = 0; cnt_nf = 0;
    first_nl = 0; first_nf = 0; first_nl2 = 0; first_hs2 = 0;
    for (int c = 1; c <= 1300; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("first_enable", vif.o_enable, 1);
        check("dflt_first_enable", vif2.o_enable, 1);
`ifdef VGA_TIMING_COORD_EN
        check("first_x", vif.o_x, 0);
        check("first_y", vif.o_y, 0);
        check("dflt_first_x", vif2.o_x, 0);
`endif
      end
      if (c <= FRAME) begin
        cnt_en += int'(vif.o_enable);
        cnt_nl += int'(vif.o_newline);
        cnt_nf += int'(vif.o_newframe);
      end
      if (c == FRAME + 1) check("next_frame_visible", vif.o_enable, 1);
      if (vif.o_newline && first_nl == 0) first_nl = c;
      if (vif.o_newframe && first_nf == 0) first_nf = c;
      if (vif2.o_newline && first_nl2 == 0) first_nl2 = c;
      if (vif2.o_hsync == 1'b0 && first_hs2 == 0) first_hs2 = c;
    end
    check("frame_enables", cnt_en, HA * VA);
    check("frame_newlines", cnt_nl, VT);
    check("frame_newframes", cnt_nf, 1);
    check("first_newline_tick", first_nl, 32);
    check("first_newframe_tick", first_nf, 608);
    check("dflt_first_newline_tick", first_nl2, 800);
    check("dflt_hsync_start_tick", first_hs2, 657);
    vif2.i_tick = 0;

    // tick every 4th clock
    for (int c = 0; c < 3000; c++) begin
      vif.i_tick = (c % 4 == 0);
      @(negedge clk);
    end

    // random tick density
    for (int c = 0; c < 3000; c++) begin
      vif.i_tick = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    // reset asserted right after the tick that emits (10,7)
    vif.i_tick = 1;
    found = 0;
    for (int c = 0; c < 2 * FRAME && !found; c++) begin
      if ((n_ticks % FRAME) == 7 * HT + 10) found = 1;
      else @(negedge clk);
    end
    if (!found) check("mid_reset_reached", 0, 1);
    @(posedge clk);
    #2;
    check("pre_reset_x_visible", vif.o_enable, 1);
    rst = 0;
    #1;
    check("async_rst_enable", vif.o_enable, 0);
    check("async_rst_hsync", vif.o_hsync, 1);
    check("async_rst_vsync", vif.o_vsync, 1);
`ifdef VGA_TIMING_COORD_EN
    check("async_rst_x", vif.o_x, 0);
    check("async_rst_y", vif.o_y, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("post_rst_enable", vif.o_enable, 1);
`ifdef VGA_TIMING_COORD_EN
    check("post_rst_x", vif.o_x, 0);
    check("post_rst_y", vif.o_y, 0);
`endif

    for (int c = 0; c < 2000; c++) begin
      vif.i_tick = $urandom_range(0, 1) != 0;
      @(negedge clk);
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
